// File: rtl/uart_program_loader_if.sv
// Byte stream from the debug UART receiver and the write port toward the
// instruction RAM, bundled for the program loader.
interface uart_program_loader_if #(
  parameter int unsigned RAM_WIDTH = 32
);
  logic [7:0]           rx_data;
  logic                 rx_done;
  logic [RAM_WIDTH-1:0] ram_addr;
  logic [RAM_WIDTH-1:0] ram_data;
  logic                 ram_we;

  modport master (
    input  rx_data, rx_done,
    output ram_addr, ram_data, ram_we
  );

  modport slave (
    output rx_data, rx_done,
    input  ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/uart_program_loader.sv
// Assembles big-endian UART bytes into 32-bit instructions and writes them to
// consecutive instruction-RAM words until the halt instruction is stored.
module uart_program_loader #(
  parameter int unsigned RAM_WIDTH   = 32,
  parameter int unsigned RAM_DEPTH   = 2048,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic                  clear,
  uart_program_loader_if.master bus,
  output logic                  loading,
  output logic                  load_done,
  output logic                  load_error,
  output logic [RAM_WIDTH-1:0]  word_count
);

  typedef enum logic [2:0] {IDLE, RECV, SETUP, WRITE, HOLD, DONE, ERROR} state_t;

  localparam logic [RAM_WIDTH-1:0] LAST_ADDR = RAM_WIDTH'(RAM_DEPTH - 1);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  // The byte assembler keeps running during SETUP/WRITE/HOLD so that a sender
  // streaming without gaps never loses a byte to the write sequence.
  logic assembling;
  assign assembling = (state == RECV) || (state == SETUP) ||
                      (state == WRITE) || (state == HOLD);

  // NOTE: every register here is assigned with <= so all updates in one edge
  // see the same pre-edge values; mixing in = would make results order-dependent.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      shift_q      <= '0;
      bus.ram_addr <= '0;
      bus.ram_data <= '0;
      bus.ram_we   <= 1'b0;
      loading      <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      word_count   <= '0;
    end else begin
      if (assembling && bus.rx_done) begin
        shift_q  <= {shift_q[15:0], bus.rx_data};
        byte_cnt <= byte_cnt + 2'd1;
      end

      case (state)
        IDLE: begin
          if (load_en) begin
            state        <= RECV;
            loading      <= 1'b1;
            byte_cnt     <= 2'd0;
            bus.ram_addr <= '0;
            word_count   <= '0;
          end
        end
        RECV: begin
          if (bus.rx_done && byte_cnt == 2'd3) begin
            bus.ram_data <= RAM_WIDTH'({shift_q, bus.rx_data});
            state        <= SETUP;
          end
        end
        SETUP: begin
          bus.ram_we <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          bus.ram_we <= 1'b0;
          state      <= HOLD;
        end
        HOLD: begin
          word_count <= word_count + RAM_WIDTH'(1);
          if (bus.ram_data[RAM_WIDTH-1 -: 6] == HALT_OPCODE) begin
            state     <= DONE;
            loading   <= 1'b0;
            load_done <= 1'b1;
          end else if (bus.ram_addr == LAST_ADDR) begin
            // RAM is full and no halt arrived: the program cannot fit.
            state      <= ERROR;
            loading    <= 1'b0;
            load_error <= 1'b1;
          end else begin
            bus.ram_addr <= bus.ram_addr + RAM_WIDTH'(1);
            state        <= RECV;
          end
        end
        DONE: begin
          if (clear) begin
            load_done <= 1'b0;
            state     <= IDLE;
          end
        end
        ERROR: begin
          if (clear) begin
            load_error <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed and randomized checks of the program loader against a word-level
// model of which instructions must land at which RAM addresses.
module tb_uart_program_loader;

  logic        clka = 1'b0;
  logic        reset = 1'b0;
  logic        load_en_a = 1'b0, clear_a = 1'b0;
  logic        load_en_b = 1'b0, clear_b = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        loading_a, load_done_a, load_error_a;
  logic        loading_b, load_done_b, load_error_b;
  logic [31:0] word_count_a, word_count_b;

  int n_cmp = 0;
  int n_err = 0;

  uart_program_loader_if #(.RAM_WIDTH(32)) bus_a ();
  uart_program_loader_if #(.RAM_WIDTH(32)) bus_b ();

  assign bus_a.rx_data = rx_data;
  assign bus_a.rx_done = rx_done;
  assign bus_b.rx_data = rx_data;
  assign bus_b.rx_done = rx_done;

  uart_program_loader #(.RAM_WIDTH(32), .RAM_DEPTH(2048), .HALT_OPCODE(6'b111111)) u_a (
    .clka(clka), .reset(reset), .load_en(load_en_a), .clear(clear_a), .bus(bus_a),
    .loading(loading_a), .load_done(load_done_a), .load_error(load_error_a),
    .word_count(word_count_a)
  );

  uart_program_loader #(.RAM_WIDTH(32), .RAM_DEPTH(4), .HALT_OPCODE(6'b111111)) u_b (
    .clka(clka), .reset(reset), .load_en(load_en_b), .clear(clear_b), .bus(bus_b),
    .loading(loading_b), .load_done(load_done_b), .load_error(load_error_b),
    .word_count(word_count_b)
  );

  always #5 clka = ~clka;

  // Observed RAM writes, captured mid-cycle while the strobe is high.
  logic [31:0] obs_a_addr[$], obs_a_data[$], obs_b_addr[$], obs_b_data[$];
  always @(negedge clka) begin
    if (bus_a.ram_we) begin
      obs_a_addr.push_back(bus_a.ram_addr);
      obs_a_data.push_back(bus_a.ram_data);
    end
    if (bus_b.ram_we) begin
      obs_b_addr.push_back(bus_b.ram_addr);
      obs_b_data.push_back(bus_b.ram_data);
    end
  end

  typedef struct {
    logic        loading, done, err, we;
    logic [31:0] addr, data, wc;
  } status_t;

  function automatic status_t st(input bit sel);
    status_t s;
    if (sel) begin
      s.loading = loading_b; s.done = load_done_b; s.err = load_error_b; s.we = bus_b.ram_we;
      s.addr = bus_b.ram_addr; s.data = bus_b.ram_data; s.wc = word_count_b;
    end else begin
      s.loading = loading_a; s.done = load_done_a; s.err = load_error_a; s.we = bus_a.ram_we;
      s.addr = bus_a.ram_addr; s.data = bus_a.ram_data; s.wc = word_count_a;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the program is a byte list; words are taken big-endian in
  // groups of four and written to addresses 0,1,2,... until halt or RAM full.
  logic [7:0]  prog[$];
  logic [31:0] exp_addr[$], exp_data[$];
  bit          exp_done, exp_err;

  function automatic void build_model(input int depth);
    logic [31:0] w;
    exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_err = 0;
    for (int i = 0; i * 4 + 3 < prog.size(); i++) begin
      w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
      exp_addr.push_back(i);
      exp_data.push_back(w);
      if (w[31:26] == 6'h3F) begin exp_done = 1; break; end
      if (i == depth - 1) begin exp_err = 1; break; end
    end
  endfunction

  function automatic void push_word(input logic [31:0] w);
    prog.push_back(w[31:24]); prog.push_back(w[23:16]);
    prog.push_back(w[15:8]);  prog.push_back(w[7:0]);
  endfunction

  function automatic logic [31:0] rand_plain();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clka);
    rx_done = 1'b0;
    repeat (gap) @(negedge clka);
  endtask

  task automatic start_load(input bit sel);
    status_t s;
    if (sel) load_en_b = 1'b1; else load_en_a = 1'b1;
    @(negedge clka);
    load_en_a = 1'b0;
    load_en_b = 1'b0;
    s = st(sel);
    check("start_loading", s.loading, 1);
    check("start_addr", s.addr, 0);
    check("start_word_count", s.wc, 0);
  endtask

  task automatic wait_end(input bit sel);
    status_t s;
    int k;
    k = 0;
    s = st(sel);
    while (!(s.done || s.err) && k < 40) begin
      check("loading_xor_flag", s.loading ^ (s.done | s.err), 1);
      @(negedge clka);
      s = st(sel);
      k++;
    end
    check("end_reached", s.done | s.err, 1);
    check("end_loading_low", s.loading, 0);
  endtask

  task automatic compare_writes(input bit sel);
    logic [31:0] oa[$], od[$];
    status_t s;
    if (sel) begin oa = obs_b_addr; od = obs_b_data; end
    else begin oa = obs_a_addr; od = obs_a_data; end
    s = st(sel);
    check("write_count", oa.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < oa.size()) begin
        check("write_addr", oa[i], exp_addr[i]);
        check("write_data", od[i], exp_data[i]);
      end
    end
    check("word_count", s.wc, exp_addr.size());
    check("load_done", s.done, exp_done);
    check("load_error", s.err, exp_err);
  endtask

  task automatic run_load(input bit sel, input int depth, input int max_gap);
    if (sel) begin obs_b_addr.delete(); obs_b_data.delete(); end
    else begin obs_a_addr.delete(); obs_a_data.delete(); end
    start_load(sel);
    foreach (prog[i]) send_byte(prog[i], $urandom_range(0, max_gap));
    wait_end(sel);
    build_model(depth);
    compare_writes(sel);
  endtask

  task automatic clear_dut(input bit sel);
    status_t s;
    if (sel) clear_b = 1'b1; else clear_a = 1'b1;
    @(negedge clka);
    clear_a = 1'b0;
    clear_b = 1'b0;
    s = st(sel);
    check("clear_done", s.done, 0);
    check("clear_error", s.err, 0);
    check("clear_loading", s.loading, 0);
  endtask

  task automatic check_all_zero(input string tag, input bit sel);
    status_t s;
    s = st(sel);
    check({tag, "_loading"}, s.loading, 0);
    check({tag, "_done"}, s.done, 0);
    check({tag, "_error"}, s.err, 0);
    check({tag, "_we"}, s.we, 0);
    check({tag, "_addr"}, s.addr, 0);
    check({tag, "_data"}, s.data, 0);
    check({tag, "_wc"}, s.wc, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    status_t s;
    logic [31:0] w;

    // Reset state.
    #2 reset = 1'b1;
    repeat (2) @(negedge clka);
    check_all_zero("reset", 0);
    check_all_zero("reset_b", 1);
    reset = 1'b0;
    @(negedge clka);

    // Bytes while idle are ignored.
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    repeat (4) @(negedge clka);
    check("idle_no_writes", obs_a_addr.size(), 0);
    check_all_zero("idle", 0);

    // Basic load.
    prog.delete();
    push_word(32'h2001_0005); push_word(32'h0022_1820); push_word(32'hFC00_0000);
    run_load(0, 2048, 1);

    // Reload from address 0 with a fresh 2-word program.
    clear_dut(0);
    prog.delete();
    push_word(rand_plain()); push_word({6'h3F, 26'($urandom)});
    run_load(0, 2048, 2);

    // Strobe timing with back-to-back bytes.
    clear_dut(0);
    obs_a_addr.delete(); obs_a_data.delete();
    start_load(0);
    w = rand_plain();
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 0);
    s = st(0);
    check("t0_we", s.we, 0); check("t0_data", s.data, w); check("t0_addr", s.addr, 0);
    @(negedge clka); s = st(0);
    check("t1_we", s.we, 1); check("t1_data", s.data, w); check("t1_addr", s.addr, 0);
    @(negedge clka); s = st(0);
    check("t2_we", s.we, 0); check("t2_data", s.data, w); check("t2_addr", s.addr, 0);
    check("t2_wc", s.wc, 0);
    @(negedge clka); s = st(0);
    check("t3_addr", s.addr, 1); check("t3_wc", s.wc, 1); check("t3_loading", s.loading, 1);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'hFC00_0001 >> (8 * i)), 0);
    wait_end(0);
    prog.delete(); push_word(w); push_word(32'hFC00_0001);
    build_model(2048);
    compare_writes(0);

    // Reset in the middle of a word.
    clear_dut(0);
    start_load(0);
    w = rand_plain();
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    repeat (2) @(negedge clka);
    s = st(0);
    check("pre_reset_addr", s.addr, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset", 0);
    @(negedge clka);
    reset = 1'b0;
    @(negedge clka);
    prog.delete();
    push_word(32'hAABB_CCDD); push_word({6'h3F, 26'($urandom)});
    run_load(0, 2048, 1);

    // Randomized programs.
    for (int r = 0; r < 4; r++) begin
      int n;
      clear_dut(0);
      n = $urandom_range(1, 5);
      prog.delete();
      for (int i = 0; i < n - 1; i++) push_word(rand_plain());
      push_word({6'h3F, 26'($urandom)});
      run_load(0, 2048, 3);
    end

    // Overflow on the 4-word instance (instance A sits in DONE meanwhile).
    prog.delete();
    for (int i = 0; i < 4; i++) push_word(rand_plain());
    run_load(1, 4, 2);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    repeat (6) @(negedge clka);
    check("overflow_no_more_writes", obs_b_addr.size(), 4);
    check("done_ignores_rx", obs_a_addr.size(), exp_addr.size() > 0 ? obs_a_addr.size() : 0);
    clear_dut(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
